// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory arbiter.
// MEM_ARB_RR_EN (see mem_arbiter) selects round-robin instead of fixed dm-first priority.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OWN_IF = 2'd1,
    OWN_DM = 2'd2
  } arb_state_e;

  localparam logic OWNER_IF = 1'b0;
  localparam logic OWNER_DM = 1'b1;

  // Widest address/data bus the reset constant can cover.
  localparam int MAX_W = 64;
  localparam logic [MAX_W-1:0] DATA_RST = '0;

  function automatic arb_state_e owner_state(input logic owner);
    return (owner == OWNER_DM) ? OWN_DM : OWN_IF;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant selection between fetch and data requests.
// With rr_en_i low the data stage always wins a tie.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic if_req_i,
  input  logic dm_req_i,
  input  logic rr_en_i,
  input  logic last_owner_i,
  output logic grant_valid_o,
  output logic grant_owner_o
);

  always_comb begin
    grant_valid_o = if_req_i | dm_req_i;
    grant_owner_o = OWNER_IF;
    if (if_req_i && dm_req_i) begin
      grant_owner_o = (rr_en_i && (last_owner_i == OWNER_DM)) ? OWNER_IF : OWNER_DM;
    end else if (dm_req_i) begin
      grant_owner_o = OWNER_DM;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch and the memory stage, one transaction at a time.
// Define MEM_ARB_RR_EN for round-robin tie-break; default is fixed dm-over-if priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW = 16,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_done,
  output logic          if_stall,
  input  logic          dm_req,
  input  logic          dm_wr,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_done,
  output logic          dm_stall,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_done,
  input  logic          mem_err,
  output logic          err
);

  arb_state_e    state_q, state_d;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          wr_q;
  logic [DW-1:0] if_rdata_q, dm_rdata_q;
  logic          if_done_q, dm_done_q;
  logic          err_q;
  logic          grant_valid, grant_owner;
  logic          rr_en, last_owner;

`ifdef MEM_ARB_RR_EN
  logic last_owner_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_owner_q <= OWNER_IF;
    end else if (state_q == IDLE && grant_valid) begin
      last_owner_q <= grant_owner;
    end
  end

  assign rr_en      = 1'b1;
  assign last_owner = last_owner_q;
`else
  assign rr_en      = 1'b0;
  assign last_owner = OWNER_IF;
`endif

  mem_arb_pick u_pick (
    .if_req_i      (if_req),
    .dm_req_i      (dm_req),
    .rr_en_i       (rr_en),
    .last_owner_i  (last_owner),
    .grant_valid_o (grant_valid),
    .grant_owner_o (grant_owner)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:           if (grant_valid) state_d = owner_state(grant_owner);
      OWN_IF, OWN_DM: if (mem_done) state_d = IDLE;
      default:        state_d = IDLE;
    endcase
  end

  // Fetch never writes, whatever wr_q holds.
  always_comb begin
    mem_rd = (state_q != IDLE) & ~wr_q;
    mem_wr = (state_q == OWN_DM) & wr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q     <= DATA_RST[AW-1:0];
      wdata_q    <= DATA_RST[DW-1:0];
      wr_q       <= 1'b0;
      if_rdata_q <= DATA_RST[DW-1:0];
      dm_rdata_q <= DATA_RST[DW-1:0];
      if_done_q  <= 1'b0;
      dm_done_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      if_done_q <= (state_q == OWN_IF) & mem_done;
      dm_done_q <= (state_q == OWN_DM) & mem_done;
      if (state_q == IDLE && grant_valid) begin
        addr_q <= (grant_owner == OWNER_DM) ? dm_addr : if_addr;
        wr_q   <= (grant_owner == OWNER_DM) & dm_wr;
        if (grant_owner == OWNER_DM) wdata_q <= dm_wdata;
      end
      if (state_q == OWN_IF && mem_done) if_rdata_q <= mem_rdata;
      if (state_q == OWN_DM && mem_done) dm_rdata_q <= mem_rdata;
      if (state_q != IDLE && mem_err) err_q <= 1'b1;
    end
  end

  // A requester that has already walked away gets no done pulse.
  assign if_done   = if_done_q & if_req;
  assign dm_done   = dm_done_q & dm_req;
  assign if_stall  = if_req & ~if_done;
  assign dm_stall  = dm_req & ~dm_done;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: transaction-level reference model plus literal spot checks.
// Expectations adapt when MEM_ARB_RR_EN is defined.
module tb_mem_arbiter;

`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        if_req, dm_req, dm_wr, mem_done, mem_err;
  logic [15:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic [15:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic        if_done, if_stall, dm_done, dm_stall, mem_rd, mem_wr, err;

  mem_arbiter #(.AW(16), .DW(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_done   (if_done),
    .if_stall  (if_stall),
    .dm_req    (dm_req),
    .dm_wr     (dm_wr),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_rdata  (dm_rdata),
    .dm_done   (dm_done),
    .dm_stall  (dm_stall),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_done  (mem_done),
    .mem_err   (mem_err),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: who owns the port (0 none, 1 fetch, 2 data) and what was latched.
  int          m_owner;
  logic [15:0] m_addr, m_wdata, m_if_rdata, m_dm_rdata;
  logic        m_wr, m_if_pend, m_dm_pend, m_err, m_last_dm;
  bit          model_on = 1'b0;

  function automatic bit pick_dm(input bit ir, input bit dr, input bit last_dm);
    if (ir && dr) return RR ? !last_dm : 1'b1;
    return dr;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_owner <= 0; m_addr <= '0; m_wdata <= '0; m_wr <= 1'b0;
      m_if_pend <= 1'b0; m_dm_pend <= 1'b0; m_if_rdata <= '0; m_dm_rdata <= '0;
      m_err <= 1'b0; m_last_dm <= 1'b0; model_on <= 1'b1;
    end else if (m_owner == 0) begin
      m_if_pend <= 1'b0;
      m_dm_pend <= 1'b0;
      if (if_req || dm_req) begin
        m_owner   <= pick_dm(if_req, dm_req, m_last_dm) ? 2 : 1;
        m_last_dm <= pick_dm(if_req, dm_req, m_last_dm);
        m_addr    <= pick_dm(if_req, dm_req, m_last_dm) ? dm_addr : if_addr;
        m_wr      <= pick_dm(if_req, dm_req, m_last_dm) & dm_wr;
        if (pick_dm(if_req, dm_req, m_last_dm)) m_wdata <= dm_wdata;
      end
    end else begin
      if (mem_err) m_err <= 1'b1;
      m_if_pend <= (m_owner == 1) && mem_done;
      m_dm_pend <= (m_owner == 2) && mem_done;
      if (mem_done) begin
        if (m_owner == 1) m_if_rdata <= mem_rdata;
        else              m_dm_rdata <= mem_rdata;
        m_owner <= 0;
      end
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      chk("mdl_mem_rd", mem_rd, (m_owner != 0) && !m_wr);
      chk("mdl_mem_wr", mem_wr, (m_owner == 2) && m_wr);
      chk("mdl_rd_wr_excl", mem_rd & mem_wr, 1'b0);
      chk("mdl_mem_addr", mem_addr, m_addr);
      if (m_owner == 2 && m_wr) chk("mdl_mem_wdata", mem_wdata, m_wdata);
      chk("mdl_if_done", if_done, m_if_pend & if_req);
      chk("mdl_dm_done", dm_done, m_dm_pend & dm_req);
      if (m_if_pend) chk("mdl_if_rdata", if_rdata, m_if_rdata);
      if (m_dm_pend) chk("mdl_dm_rdata", dm_rdata, m_dm_rdata);
      chk("mdl_if_stall", if_stall, if_req & ~(m_if_pend & if_req));
      chk("mdl_dm_stall", dm_stall, dm_req & ~(m_dm_pend & dm_req));
      chk("mdl_err", err, m_err);
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    bit first_dm;
    rst = 1'b1; if_req = 0; dm_req = 0; dm_wr = 0; mem_done = 0; mem_err = 0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0; mem_rdata = '0;
    nxt(); nxt();
    rst = 1'b0;
    neg();
    chk("rst_mem_rd", mem_rd, 0);       chk("rst_mem_wr", mem_wr, 0);
    chk("rst_mem_addr", mem_addr, 0);   chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_if_rdata", if_rdata, 0);   chk("rst_dm_rdata", dm_rdata, 0);
    chk("rst_if_done", if_done, 0);     chk("rst_dm_done", dm_done, 0);
    chk("rst_err", err, 0);
    nxt();

    // Single fetch, memory answers after one cycle.
    if_req = 1; if_addr = 16'h0040;
    neg(); chk("fetch_stall_t", if_stall, 1); nxt();
    mem_done = 1; mem_rdata = 16'hBEEF;
    neg(); chk("fetch_rd_t1", mem_rd, 1); chk("fetch_addr_t1", mem_addr, 16'h0040); nxt();
    mem_done = 0;
    neg(); chk("fetch_done_t2", if_done, 1); chk("fetch_rdata_t2", if_rdata, 16'hBEEF);
    chk("fetch_stall_t2", if_stall, 0); chk("fetch_rd_t2", mem_rd, 0);
    #1 if_req = 0; nxt();
    neg(); chk("fetch_rd_t3", mem_rd, 0); nxt();

    // Long data-read miss: memory answers at t+6.
    dm_req = 1; dm_wr = 0; dm_addr = 16'h2000;
    for (int k = 0; k <= 7; k++) begin
      mem_done  = (k == 6);
      mem_rdata = (k == 6) ? 16'h5A5A : 16'h0000;
      neg();
      if (k <= 6) chk("miss_stall", dm_stall, 1);
      if (k >= 1 && k <= 6) chk("miss_rd_held", mem_rd, 1);
      if (k == 0) chk("miss_rd_t0", mem_rd, 0);
      if (k == 7) begin
        chk("miss_done_t7", dm_done, 1); chk("miss_rdata_t7", dm_rdata, 16'h5A5A);
        chk("miss_rd_t7", mem_rd, 0);
        #1 dm_req = 0;
      end
      nxt();
    end
    mem_done = 0;

    // Simultaneous requests; last grant was data, so round-robin favours fetch.
    first_dm = !RR;
    if_req = 1; if_addr = 16'h0040;
    dm_req = 1; dm_wr = 1; dm_addr = 16'h1000; dm_wdata = 16'h1234;
    neg(); nxt();
    mem_done = 1; mem_rdata = first_dm ? 16'h0000 : 16'hCAFE;
    neg(); chk("sim1_wr", mem_wr, first_dm); chk("sim1_rd", mem_rd, !first_dm);
    chk("sim1_addr", mem_addr, first_dm ? 16'h1000 : 16'h0040);
    if (first_dm) chk("sim1_wdata", mem_wdata, 16'h1234);
    nxt();
    mem_done = 0;
    neg(); chk("sim2_dm_done", dm_done, first_dm); chk("sim2_if_done", if_done, !first_dm);
    #1 if (first_dm) dm_req = 0; else if_req = 0;
    nxt();
    mem_done = 1; mem_rdata = first_dm ? 16'hCAFE : 16'h0000;
    neg(); chk("sim3_wr", mem_wr, !first_dm); chk("sim3_rd", mem_rd, first_dm);
    chk("sim3_addr", mem_addr, first_dm ? 16'h0040 : 16'h1000);
    if (!first_dm) chk("sim3_wdata", mem_wdata, 16'h1234);
    nxt();
    mem_done = 0;
    neg(); chk("sim4_dm_done", dm_done, !first_dm); chk("sim4_if_done", if_done, first_dm);
    chk("sim_if_rdata", if_rdata, 16'hCAFE);
    #1 begin if_req = 0; dm_req = 0; end
    nxt();

    // Data write whose requester gives up at t+2; write still finishes.
    dm_req = 1; dm_wr = 1; dm_addr = 16'h3000; dm_wdata = 16'h7777;
    neg(); nxt();
    neg(); chk("abn_wr_t1", mem_wr, 1); nxt();
    dm_req = 0;
    neg(); chk("abn_wr_t2", mem_wr, 1); nxt();
    neg(); chk("abn_wr_t3", mem_wr, 1); nxt();
    mem_done = 1;
    neg(); chk("abn_wr_t4", mem_wr, 1); chk("abn_wdata_t4", mem_wdata, 16'h7777); nxt();
    mem_done = 0;
    neg(); chk("abn_done_t5", dm_done, 0); chk("abn_wr_t5", mem_wr, 0); chk("abn_rd_t5", mem_rd, 0);
    nxt();

    // Reset during a data read, with mem_done colliding with reset.
    dm_req = 1; dm_wr = 0; dm_addr = 16'h4000;
    nxt(); nxt(); nxt();
    rst = 1; mem_done = 1; mem_rdata = 16'h9999;
    neg(); chk("rstop_rd_t3", mem_rd, 1); nxt();
    rst = 0; mem_done = 0;
    neg(); chk("rstop_rd_t4", mem_rd, 0); chk("rstop_done_t4", dm_done, 0); chk("rstop_err_t4", err, 0);
    #1 dm_req = 0;
    nxt();

    // mem_done / mem_err while idle are ignored.
    mem_done = 1; mem_err = 1; mem_rdata = 16'h3333;
    neg(); nxt();
    mem_done = 0; mem_err = 0;
    neg(); chk("idle_err", err, 0); chk("idle_rd", mem_rd, 0); nxt();

    // Error during a fetch stays sticky until reset.
    if_req = 1; if_addr = 16'h0050;
    nxt();
    mem_done = 1; mem_err = 1; mem_rdata = 16'h1111;
    neg(); chk("err_t1", err, 0); nxt();
    mem_done = 0; mem_err = 0;
    neg(); chk("err_t2", err, 1); chk("err_if_done", if_done, 1); chk("err_if_rdata", if_rdata, 16'h1111);
    #1 if_req = 0;
    nxt();
    dm_req = 1; dm_wr = 0; dm_addr = 16'h0060;
    nxt();
    mem_done = 1; mem_rdata = 16'h2222;
    neg(); chk("err_hold_a", err, 1); nxt();
    mem_done = 0;
    neg(); chk("err_hold_b", err, 1); chk("err_dm_rdata", dm_rdata, 16'h2222);
    #1 dm_req = 0;
    nxt();
    rst = 1;
    nxt();
    rst = 0;
    neg(); chk("err_cleared", err, 0); nxt();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbiter that shares the single unified cache/memory system between the instruction-fetch stage and the memory stage of the pipelined processor. Each requester sees a simple req/done port with its own stall output. The arbiter owns the memory system's Rd/Wr/Addr/DataIn port and sequences one transaction at a time through a small state machine. Read data is latched and returned to the owning requester.

## Interface

Parameters:
- AW, 16, address width
- DW, 16, data width

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-high
- if_req  in  1  fetch read request; held high until if_done
- if_addr  in  AW  fetch address; stable while if_req high
- if_rdata  out  DW  fetched instruction; valid in the if_done cycle
- if_done  out  1  one-cycle completion pulse to fetch
- if_stall  out  1  fetch must hold; equals if_req & ~if_done
- dm_req  in  1  data request; held high until dm_done
- dm_wr  in  1  1 = write, 0 = read; stable while dm_req high
- dm_addr  in  AW  data address
- dm_wdata  in  DW  write data
- dm_rdata  out  DW  load data; valid in the dm_done cycle
- dm_done  out  1  one-cycle completion pulse to memory stage
- dm_stall  out  1  equals dm_req & ~dm_done
- mem_rd  out  1  read command to memory system
- mem_wr  out  1  write command to memory system
- mem_addr  out  AW  latched address
- mem_wdata  out  DW  latched write data
- mem_rdata  in  DW  memory system read data; valid with mem_done
- mem_done  in  1  memory system completion
- mem_err  in  1  memory system error
- err  out  1  sticky error flag

## Operation

- States: IDLE, OWN_IF, OWN_DM.
- IDLE:
  - If any request is pending, pick an owner.
  - Latch addr/wdata/wr into mem_* registers and move to OWN_IF or OWN_DM.
  - No request: stay in IDLE.
- Default tie-break: dm wins over if, because the memory stage holds the older instruction.
- OWN_x:
  - mem_rd = ~latched_wr and mem_wr = latched_wr, held high every cycle until mem_done.
  - On mem_done: latch mem_rdata into the owner's rdata register, drop mem_rd/mem_wr, go to IDLE.
  - The owner's done pulse is registered and appears in the cycle after mem_done.
- Fetch is always a read; mem_wr is never asserted for OWN_IF.
- Requester drops req mid-transaction:
  - The transaction still completes, so writes are never torn.
  - The done pulse is suppressed if req is low in the pulse cycle.
- mem_done while in IDLE is ignored.
- mem_err while in an OWN state sets err. err is cleared only by rst.
- mem_rd and mem_wr are never high together.
- Outputs after reset: state IDLE, mem_rd = mem_wr = 0, mem_addr = mem_wdata = 0, if_rdata = dm_rdata = 0, if_done = dm_done = 0, err = 0.

## Timing

- Request sampled in IDLE at cycle t.
- Owner state and mem_rd/mem_wr asserted at t+1.
- mem_done at cycle d ≥ t+1.
- done pulse and rdata valid at d+1, when the state is IDLE again.
- Next grant is sampled at d+1; the next command is issued at d+2.
- Minimum turnaround is 3 cycles per transaction.
- A requester that keeps req high after its done pulse is treated as a new request at d+1.
- rst high in any cycle:
  - State is IDLE in the next cycle.
  - The in-flight transaction is abandoned; the memory system shares rst.
  - No done pulse is issued.

## Configuration

- MEM_ARB_RR_EN defined:
  - Round-robin tie-break. A last-owner register (reset value: fetch) tracks the previous grant.
  - On a simultaneous request, the requester that did not own last wins.
  - A single request is granted immediately regardless of the register.
- MEM_ARB_RR_EN undefined: fixed priority, dm over if; no last-owner register.

## Structure

- Package mem_arb_pkg holds:
  - state enum (IDLE, OWN_IF, OWN_DM)
  - owner id constants (OWNER_IF, OWNER_DM)
  - reset constants for data widths
- One sub-module, mem_arb_pick: combinational grant selection from if_req, dm_req and last owner. The RR input is tied off when MEM_ARB_RR_EN is undefined.
- Data latches and the FSM stay in mem_arbiter.

## Test plan

- Single fetch: if_req=1, if_addr=0x0040; mem_done at t+1 with mem_rdata=0xBEEF → mem_rd high at t+1 only, if_done and if_rdata=0xBEEF at t+2, if_stall low at t+2.
- Simultaneous: if_req and dm_req at t, dm_wr=1, dm_addr=0x1000, dm_wdata=0x1234:
  - Fixed priority: mem_wr first with 0x1000/0x1234, dm_done first, then the fetch is granted.
  - MEM_ARB_RR_EN after a prior dm grant: fetch first.
- Long miss: mem_done at t+6 → mem_rd held t+1..t+6; dm_stall high t..t+6; dm_done at t+7.
- Abandoned request: dm_req drops at t+2 with mem_done at t+4 → mem_wr held to t+4, no dm_done, state IDLE at t+5.
- Reset mid-op: rst at t+3 of an OWN_DM read → mem_rd=0 and IDLE at t+4; no done pulse; err=0.
- Error: mem_err=1 with mem_done in OWN_IF → err=1 from the next cycle, stays 1 through later transactions until rst.
